i2c_bus_monitor: RTL and testbench

- Passive observer on the resolved shared I2C bus nets (SDA/SCL after wired-AND resolution).
- Decodes START, repeated START and STOP, the address/RW byte, each data byte and the ACK/NACK bit.
- Presents each completed byte on a valid/ready stream for a debug/log consumer downstream of the bus.
- Never drives the bus.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_sync_edge.sv | 32 +++
 rtl/i2c_bus_monitor.sv | 172 +++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
package i2c_pkg;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_ADDR,
      MS_DATA
   } mon_state_t;

   localparam int I2C_BITS_PER_FRAME = 9;
   localparam int I2C_ADDR_W         = 7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for one asynchronous bus line, plus a delay flop
// that yields single-cycle rise/fall strobes on the synchronized level.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Flops preset high so an idle-high bus produces no edges after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: decodes START/STOP, address and data bytes with their
// ACK bit, and hands each completed byte to a single-entry valid/ready stream.
module i2c_bus_monitor
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       bus_busy,
   output logic       start_pulse,
   output logic       rep_start,
   output logic       stop_pulse,
   output logic       frame_err,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic [7:0] byte_data,
   output logic       byte_is_addr,
   output logic       byte_ack,
   output logic [6:0] last_addr,
   output logic       last_rw,
   output logic       overflow,
   input  logic       overflow_clr
);

   localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_FRAME - 1);

   logic s_sda, sda_rise, sda_fall;
   logic s_scl, scl_rise, scl_fall;
   logic start_det, stop_det;

   mon_state_t            state_q, state_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic                  busy_q, busy_d;
   logic                  start_pulse_q, start_pulse_d;
   logic                  rep_start_q, rep_start_d;
   logic                  stop_pulse_q, stop_pulse_d;
   logic                  frame_err_q, frame_err_d;
   logic                  valid_q, valid_d;
   logic [7:0]            data_q, data_d;
   logic                  is_addr_q, is_addr_d;
   logic                  ack_q, ack_d;
   logic [I2C_ADDR_W-1:0] last_addr_q, last_addr_d;
   logic                  last_rw_q, last_rw_d;
   logic                  overflow_q, overflow_d;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
      .clk(clk), .rst(rst), .d_i(sda_in),
      .level_o(s_sda), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
      .clk(clk), .rst(rst), .d_i(scl_in),
      .level_o(s_scl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   // SCL must be high in both this and the previous cycle; an SDA edge that
   // coincides with an SCL edge is ordinary data timing, not a condition.
   assign start_det = s_scl & ~scl_rise & ~scl_fall & sda_fall;
   assign stop_det  = s_scl & ~scl_rise & ~scl_fall & sda_rise;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      busy_d        = busy_q;
      start_pulse_d = 1'b0;
      rep_start_d   = 1'b0;
      stop_pulse_d  = 1'b0;
      frame_err_d   = 1'b0;
      valid_d       = valid_q;
      data_d        = data_q;
      is_addr_d     = is_addr_q;
      ack_d         = ack_q;
      last_addr_d   = last_addr_q;
      last_rw_d     = last_rw_q;
      overflow_d    = overflow_q;

      if (valid_q && byte_ready) valid_d = 1'b0;
      if (overflow_clr) overflow_d = 1'b0;

      if (start_det) begin
         state_d       = MS_ADDR;
         bit_cnt_d     = '0;
         start_pulse_d = 1'b1;
         rep_start_d   = busy_q;
         busy_d        = 1'b1;
         frame_err_d   = (bit_cnt_q != '0);
      end else if (stop_det) begin
         state_d      = MS_IDLE;
         bit_cnt_d    = '0;
         stop_pulse_d = 1'b1;
         busy_d       = 1'b0;
         frame_err_d  = (bit_cnt_q != '0);
      end else if (scl_rise && state_q != MS_IDLE) begin
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = MS_DATA;
            if (state_q == MS_ADDR) begin
               last_addr_d = shift_q[7:1];
               last_rw_d   = shift_q[0];
            end
            // Single holding register: a byte arriving while one is still
            // unaccepted is dropped and flagged instead of overwriting.
            if (!valid_q || byte_ready) begin
               valid_d   = 1'b1;
               data_d    = shift_q;
               is_addr_d = (state_q == MS_ADDR);
               ack_d     = ~s_sda;
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            shift_d   = {shift_q[6:0], s_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= MS_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         busy_q        <= 1'b0;
         start_pulse_q <= 1'b0;
         rep_start_q   <= 1'b0;
         stop_pulse_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         valid_q       <= 1'b0;
         data_q        <= '0;
         is_addr_q     <= 1'b0;
         ack_q         <= 1'b0;
         last_addr_q   <= '0;
         last_rw_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         busy_q        <= busy_d;
         start_pulse_q <= start_pulse_d;
         rep_start_q   <= rep_start_d;
         stop_pulse_q  <= stop_pulse_d;
         frame_err_q   <= frame_err_d;
         valid_q       <= valid_d;
         data_q        <= data_d;
         is_addr_q     <= is_addr_d;
         ack_q         <= ack_d;
         last_addr_q   <= last_addr_d;
         last_rw_q     <= last_rw_d;
         overflow_q    <= overflow_d;
      end
   end

   assign bus_busy     = busy_q;
   assign start_pulse  = start_pulse_q;
   assign rep_start    = rep_start_q;
   assign stop_pulse   = stop_pulse_q;
   assign frame_err    = frame_err_q;
   assign byte_valid   = valid_q;
   assign byte_data    = data_q;
   assign byte_is_addr = is_addr_q;
   assign byte_ack     = ack_q;
   assign last_addr    = last_addr_q;
   assign last_rw      = last_rw_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: bit-banged bus frames, byte scoreboard and
// event counters for START/STOP/frame-error pulses.
module tb_i2c_bus_monitor;
   import i2c_pkg::*;

   localparam int SYNC = 2;
   localparam int Q    = 4;   // clocks per quarter SCL period

   logic       clk = 1'b0;
   logic       rst;
   logic       sda_in, scl_in;
   logic       bus_busy, start_pulse, rep_start, stop_pulse, frame_err;
   logic       byte_valid, byte_ready;
   logic [7:0] byte_data;
   logic       byte_is_addr, byte_ack;
   logic [6:0] last_addr;
   logic       last_rw, overflow, overflow_clr;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0, rep_cnt = 0, stop_cnt = 0, ferr_cnt = 0;
   logic last_stop_ferr = 1'b0;
   logic [9:0] exp_q[$];   // {is_addr, ack, data}

   i2c_bus_monitor #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .sda_in(sda_in), .scl_in(scl_in),
      .bus_busy(bus_busy), .start_pulse(start_pulse), .rep_start(rep_start),
      .stop_pulse(stop_pulse), .frame_err(frame_err),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
      .byte_is_addr(byte_is_addr), .byte_ack(byte_ack),
      .last_addr(last_addr), .last_rw(last_rw),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always begin
      logic [10:0] got, exp;
      @(negedge clk);
      #1;
      if (start_pulse) begin
         start_cnt++;
         if (rep_start) rep_cnt++;
      end
      if (stop_pulse) begin
         stop_cnt++;
         last_stop_ferr = frame_err;
      end
      if (frame_err) ferr_cnt++;
      if (byte_valid && byte_ready) begin
         got = {1'b1, byte_is_addr, byte_ack, byte_data};
         exp = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 11'h0;
         check("byte", 32'(got), 32'(exp));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, input logic raise_ready = 1'b0);
      sda_in = b;
      wait_clks(Q);
      scl_in = 1'b1;
      wait_clks(2);
      if (raise_ready) byte_ready = 1'b1;
      wait_clks(2 * Q - 2);
      scl_in = 1'b0;
      wait_clks(Q);
   endtask

   task automatic bus_start();
      int lat;
      lat = 0;
      sda_in = 1'b1;
      wait_clks(Q);
      scl_in = 1'b1;
      wait_clks(Q);
      sda_in = 1'b0;
      for (int i = 1; i <= Q; i++) begin
         wait_clks(1);
         if (start_pulse && lat == 0) lat = i;
      end
      check("start_latency", 32'(lat), 32'(SYNC + 1));
      scl_in = 1'b0;
      wait_clks(Q);
   endtask

   task automatic bus_stop();
      sda_in = 1'b0;
      wait_clks(Q);
      scl_in = 1'b1;
      wait_clks(Q);
      sda_in = 1'b1;
      wait_clks(2 * Q);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic is_addr, input logic nack,
                            input logic push = 1'b1, input logic ready_at_ack = 1'b0);
      if (push) exp_q.push_back({is_addr, ~nack, d});
      for (int i = 7; i >= 0; i--) bus_bit(d[i]);
      bus_bit(nack, ready_at_ack);
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({bus_busy, start_pulse, rep_start, stop_pulse, frame_err, byte_valid,
                  byte_data, byte_is_addr, byte_ack, last_addr, last_rw, overflow});
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int s0, r0, p0, f0;
      rst = 1'b1; sda_in = 1'b1; scl_in = 1'b1; byte_ready = 1'b1; overflow_clr = 1'b0;
      wait_clks(3);
      check("reset_outputs", out_vec(), 32'h0);
      check("reset_state", 32'(dut.state_q), 32'(MS_IDLE));
      rst = 1'b0;
      wait_clks(4);

      // Write frame
      s0 = start_cnt; p0 = stop_cnt;
      bus_start();
      check("wr_start_cnt", 32'(start_cnt - s0), 32'd1);
      check("wr_rep_cnt", 32'(rep_cnt), 32'd0);
      send_byte(8'h84, 1'b1, 1'b0);
      send_byte(8'hA5, 1'b0, 1'b0);
      check("wr_busy", 32'(bus_busy), 32'd1);
      check("wr_last_addr", 32'(last_addr), 32'h42);
      check("wr_last_rw", 32'(last_rw), 32'd0);
      bus_stop();
      check("wr_stop_cnt", 32'(stop_cnt - p0), 32'd1);
      check("wr_busy_after", 32'(bus_busy), 32'd0);

      // Read frame ending in NACK
      bus_start();
      send_byte(8'h55, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b0, 1'b1);
      check("rd_last_addr", 32'(last_addr), 32'h2A);
      check("rd_last_rw", 32'(last_rw), 32'd1);
      bus_stop();

      // Repeated START
      r0 = rep_cnt;
      bus_start();
      send_byte(8'hB8, 1'b1, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      bus_start();
      check("rs_rep_cnt", 32'(rep_cnt - r0), 32'd1);
      check("rs_busy", 32'(bus_busy), 32'd1);
      send_byte(8'hB9, 1'b1, 1'b0);
      check("rs_last_rw", 32'(last_rw), 32'd1);
      bus_stop();

      // Backpressure and overflow
      byte_ready = 1'b0;
      bus_start();
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0, 1'b0);
      check("bp_valid", 32'(byte_valid), 32'd1);
      check("bp_hold_data", 32'(byte_data), 32'h11);
      check("bp_overflow_set", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      wait_clks(1);
      overflow_clr = 1'b0;
      wait_clks(1);
      check("bp_overflow_clr", 32'(overflow), 32'd0);
      send_byte(8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
      check("bp_no_overflow", 32'(overflow), 32'd0);
      check("bp_drained", 32'(byte_valid), 32'd0);
      bus_stop();

      // Abort mid-byte
      bus_start();
      send_byte(8'h90, 1'b1, 1'b0);
      bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
      f0 = ferr_cnt; p0 = stop_cnt;
      bus_stop();
      check("ab_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
      check("ab_stop_cnt", 32'(stop_cnt - p0), 32'd1);
      check("ab_ferr_with_stop", 32'(last_stop_ferr), 32'd1);
      check("ab_state", 32'(dut.state_q), 32'(MS_IDLE));
      check("ab_no_valid", 32'(byte_valid), 32'd0);

      // Reset mid-byte
      bus_start();
      bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
      rst = 1'b1;
      wait_clks(2);
      check("mr_outputs", out_vec(), 32'h0);
      check("mr_state", 32'(dut.state_q), 32'(MS_IDLE));
      rst = 1'b0;
      for (int i = 0; i < 15; i++) bus_bit(1'($urandom_range(0, 1)));
      check("mr_no_valid", 32'(byte_valid), 32'd0);
      check("mr_busy", 32'(bus_busy), 32'd0);
      p0 = stop_cnt;
      bus_stop();
      check("mr_idle_stop", 32'(stop_cnt - p0), 32'd1);
      check("mr_idle_stop_noferr", 32'(last_stop_ferr), 32'd0);

      wait_clks(4);
      check("sb_remaining", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
